// File: rtl/logica_siguiente_estado_if.sv
// Elevator controller bus: buttons, floor sensor, state loop, outputs.
// master drives stimulus and the state register; slave is the controller.
interface logica_siguiente_estado_if #(
  parameter int N_PISOS = 4
);
  localparam int W = (N_PISOS > 1) ? $clog2(N_PISOS) : 1;

  logic [N_PISOS-1:0] boton;
  logic [W-1:0]       piso_actual;
  logic               en_piso;
  logic [1:0]         Q;
  logic [1:0]         D;
  logic               motor_sube;
  logic               motor_baja;
  logic               puerta;
  logic [N_PISOS-1:0] pendientes;

  modport master (
    output boton, piso_actual, en_piso, Q,
    input  D, motor_sube, motor_baja,
    input  puerta, pendientes
  );

  modport slave (
    input  boton, piso_actual, en_piso, Q,
    output D, motor_sube, motor_baja,
    output puerta, pendientes
  );
endinterface

// File: rtl/logica_siguiente_estado.sv
// Elevator next-state logic: request latch, door timer, direction memory.
// Ports: clk, rst_n (sync, active-low), bus (slave); ASCENSOR_PARADA_EN adds parada.
module logica_siguiente_estado #(
  parameter int N_PISOS  = 4,
  parameter int T_PUERTA = 8
) (
  input  logic clk,
  input  logic rst_n,
`ifdef ASCENSOR_PARADA_EN
  input  logic parada,
`endif
  logica_siguiente_estado_if.slave bus
);
  typedef enum logic [1:0] {
    REPOSO   = 2'b00,
    SUBIENDO = 2'b01,
    BAJANDO  = 2'b10,
    PUERTA   = 2'b11
  } estado_t;

  localparam logic [7:0] T_FIN = 8'(T_PUERTA - 1);

  estado_t            q;
  estado_t            d_nxt;
  logic [N_PISOS-1:0] pend;
  logic [N_PISOS-1:0] pend_nxt;
  logic [7:0]         timer;
  logic [7:0]         timer_nxt;
  logic               ult_sube;
  logic               stop;
  logic               hay_arriba;
  logic               hay_abajo;
  logic               pend_aqui;
  logic               en_tope;
  logic               en_fondo;
  logic               boton_aqui;

  assign q = estado_t'(bus.Q);

`ifdef ASCENSOR_PARADA_EN
  assign stop = parada;
`else
  assign stop = 1'b0;
`endif

  assign pend_aqui  = pend[bus.piso_actual];
  assign boton_aqui = bus.boton[bus.piso_actual];
  assign en_tope    = int'(bus.piso_actual) == N_PISOS - 1;
  assign en_fondo   = bus.piso_actual == '0;

  always_comb begin
    hay_arriba = 1'b0;
    hay_abajo  = 1'b0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (pend[i]) begin
        if (i > int'(bus.piso_actual))
          hay_arriba = 1'b1;
        if (i < int'(bus.piso_actual))
          hay_abajo = 1'b1;
      end
    end
  end

  always_comb begin
    d_nxt = REPOSO;
    if (rst_n && !stop) begin
      unique case (q)
        REPOSO: begin
          if (bus.en_piso) begin
            if (pend_aqui)
              d_nxt = PUERTA;
            else if (ult_sube) begin
              if (hay_arriba)
                d_nxt = SUBIENDO;
              else if (hay_abajo)
                d_nxt = BAJANDO;
            end else begin
              if (hay_abajo)
                d_nxt = BAJANDO;
              else if (hay_arriba)
                d_nxt = SUBIENDO;
            end
          end
        end
        SUBIENDO: begin
          d_nxt = SUBIENDO;
          if (bus.en_piso && (pend_aqui || en_tope))
            d_nxt = PUERTA;
        end
        BAJANDO: begin
          d_nxt = BAJANDO;
          if (bus.en_piso && (pend_aqui || en_fondo))
            d_nxt = PUERTA;
        end
        PUERTA: begin
          d_nxt = (timer == T_FIN) ? REPOSO : PUERTA;
        end
      endcase
    end
  end

  // Door clear is applied after the OR so it wins over a same-cycle press.
  always_comb begin
    pend_nxt = pend | bus.boton;
    if (q == PUERTA && bus.en_piso)
      pend_nxt[bus.piso_actual] = 1'b0;
  end

  always_comb begin
    timer_nxt = timer;
    if (q != PUERTA)
      timer_nxt = '0;
    else if (stop)
      timer_nxt = timer;
    else if (boton_aqui)
      timer_nxt = '0;
    else if (timer != T_FIN)
      timer_nxt = timer + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend     <= '0;
      timer    <= '0;
      ult_sube <= 1'b1;
    end else begin
      pend  <= pend_nxt;
      timer <= timer_nxt;
      if (q == SUBIENDO)
        ult_sube <= 1'b1;
      else if (q == BAJANDO)
        ult_sube <= 1'b0;
    end
  end

  assign bus.D          = d_nxt;
  assign bus.motor_sube = q == SUBIENDO;
  assign bus.motor_baja = q == BAJANDO;
  assign bus.puerta     = q == PUERTA;
  assign bus.pendientes = pend;
endmodule

// File: tb/tb_logica_siguiente_estado.sv
// Scoreboard bench for logica_siguiente_estado.
// Driver queues expectations; a negedge monitor pops and compares.
module tb_logica_siguiente_estado;
  logic clk = 1'b0;
  logic rst_n;
`ifdef ASCENSOR_PARADA_EN
  logic parada;
`endif

  logica_siguiente_estado_if #(.N_PISOS(4)) bus ();

  logica_siguiente_estado #(
    .N_PISOS (4),
    .T_PUERTA(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef ASCENSOR_PARADA_EN
    .parada(parada),
`endif
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] d;
    logic [3:0] pend;
    logic [2:0] mot;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [1:0] REP = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] BAJ = 2'b10;
  localparam logic [1:0] PUE = 2'b11;

  task automatic expect_(input string n, input logic [1:0] d,
                         input logic [3:0] p, input logic [2:0] m);
    exp_t e;
    e.name = n;
    e.d    = d;
    e.pend = p;
    e.mot  = m;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [2:0] m;
      e = sb.pop_front();
      m = {bus.motor_sube, bus.motor_baja, bus.puerta};
      checks++;
      if (bus.D !== e.d || bus.pendientes !== e.pend || m !== e.mot) begin
        errors++;
        $display("FAIL %s: D=%b pend=%b mot=%b required D=%b pend=%b mot=%b",
                 e.name, bus.D, bus.pendientes, m, e.d, e.pend, e.mot);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n           = 1'b0;
    bus.Q           = REP;
    bus.boton       = 4'b0000;
    bus.en_piso     = 1'b0;
    bus.piso_actual = 2'd0;
`ifdef ASCENSOR_PARADA_EN
    parada = 1'b0;
`endif
    cyc();
    cyc();
    expect_("rst", REP, 4'b0000, 3'b000);
    cyc();
    bus.Q = SUB;
    expect_("rst_q_sube", REP, 4'b0000, 3'b100);

    cyc();
    rst_n = 1'b1;
    bus.Q = REP;
    bus.en_piso = 1'b1;
    bus.piso_actual = 2'd0;
    bus.boton = 4'b0100;
    expect_("t1_pre", REP, 4'b0000, 3'b000);
    cyc();
    bus.boton = 4'b0000;
    expect_("t1_post", SUB, 4'b0100, 3'b000);

    cyc();
    bus.Q = SUB;
    bus.en_piso = 1'b0;
    expect_("t2_travel", SUB, 4'b0100, 3'b100);
    cyc();
    bus.en_piso = 1'b1;
    bus.piso_actual = 2'd1;
    expect_("t2_f1", SUB, 4'b0100, 3'b100);
    cyc();
    bus.piso_actual = 2'd2;
    expect_("t2_f2", PUE, 4'b0100, 3'b100);
    cyc();
    bus.Q = PUE;
    expect_("t2_open", PUE, 4'b0100, 3'b001);
    cyc();
    expect_("t2_clr", PUE, 4'b0000, 3'b001);

    cyc();
    bus.Q = REP;
    expect_("idle", REP, 4'b0000, 3'b000);
    cyc();
    bus.Q = PUE;
    for (int k = 0; k < 6; k++) begin
      if (k == 5)
        bus.boton = 4'b0100;
      expect_("dwell1", PUE, 4'b0000, 3'b001);
      cyc();
    end
    bus.boton = 4'b0000;
    expect_("clr_beats_boton", PUE, 4'b0000, 3'b001);
    for (int k = 0; k < 6; k++) begin
      cyc();
      expect_("dwell2", PUE, 4'b0000, 3'b001);
    end
    cyc();
    expect_("dwell_end", REP, 4'b0000, 3'b001);
    cyc();
    expect_("timer_sat", REP, 4'b0000, 3'b001);

    cyc();
    bus.Q = REP;
    bus.piso_actual = 2'd1;
    bus.boton = 4'b1001;
    expect_("t4_pre", REP, 4'b0000, 3'b000);
    cyc();
    bus.boton = 4'b0000;
    expect_("t4_up", SUB, 4'b1001, 3'b000);
    cyc();
    bus.Q = BAJ;
    expect_("t4_baj", BAJ, 4'b1001, 3'b010);
    cyc();
    bus.Q = REP;
    expect_("t4_down", BAJ, 4'b1001, 3'b000);

    cyc();
    rst_n = 1'b0;
    expect_("t5_rst_comb", REP, 4'b1001, 3'b000);
    cyc();
    rst_n = 1'b1;
    bus.en_piso = 1'b0;
    bus.boton = 4'b1010;
    expect_("t5_pre", REP, 4'b0000, 3'b000);
    cyc();
    bus.boton = 4'b0000;
    expect_("t5_no_en", REP, 4'b1010, 3'b000);
    cyc();
    rst_n = 1'b0;
    bus.Q = SUB;
    expect_("t5_rst_hold", REP, 4'b1010, 3'b100);
    cyc();
    expect_("t5_rst_clr", REP, 4'b0000, 3'b100);

    cyc();
    rst_n = 1'b1;
    bus.en_piso = 1'b1;
    bus.piso_actual = 2'd3;
    bus.Q = SUB;
    expect_("lim_top", PUE, 4'b0000, 3'b100);
    cyc();
    bus.Q = BAJ;
    bus.piso_actual = 2'd0;
    expect_("lim_bottom", PUE, 4'b0000, 3'b010);
    cyc();
    bus.piso_actual = 2'd2;
    expect_("baj_mid", BAJ, 4'b0000, 3'b010);
    cyc();
    bus.Q = SUB;
    expect_("sub_mid", SUB, 4'b0000, 3'b100);

`ifdef ASCENSOR_PARADA_EN
    cyc();
    parada = 1'b1;
    bus.boton = 4'b0010;
    expect_("stop", REP, 4'b0000, 3'b100);
    cyc();
    bus.boton = 4'b0000;
    expect_("stop_keep", REP, 4'b0010, 3'b100);
    cyc();
    parada = 1'b0;
    bus.Q = REP;
    bus.piso_actual = 2'd0;
    expect_("resume", SUB, 4'b0010, 3'b000);
`endif

    cyc();
    cyc();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/logica_siguiente_estado.md
LOGICA_SIGUIENTE_ESTADO -- requirements
Module: logica_siguiente_estado

Interface
REQ-001 Parameter N_PISOS, default 4: number of floors; floor index width is clog2(N_PISOS).
REQ-002 Parameter T_PUERTA, default 8: door-open dwell in clk cycles; legal range 2..255.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock shared with the downstream state register.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 boton  in  N_PISOS  call buttons, one bit per floor, level or single-cycle pulse.
REQ-007 piso_actual  in  clog2(N_PISOS)  floor sensor index, valid only when en_piso=1.
REQ-008 en_piso  in  1  car aligned at floor piso_actual.
REQ-009 Q  in  2  current state from the downstream state register.
REQ-010 D  out  2  next state to the state register; encoding REPOSO=00, SUBIENDO=01, BAJANDO=10, PUERTA=11.
REQ-011 motor_sube, motor_baja, puerta  out  1 each  decoded from Q: Q==SUBIENDO, Q==BAJANDO, Q==PUERTA.
REQ-012 pendientes  out  N_PISOS  registered pending-request vector.

Function
REQ-013 D SHALL be combinational from Q, en_piso, piso_actual, pendientes, timer and ultima_dir; state changes one clk after D changes.
REQ-014 pendientes[i] SHALL set on the clk edge after boton[i]=1; it clears only as defined in REQ-019.
REQ-015 REPOSO: en_piso and pendientes[piso_actual] -> PUERTA; else a request on the ultima_dir side -> that direction; else a request on the other side -> that direction; else REPOSO.
REQ-016 "Above" means index > piso_actual and "below" means index < piso_actual; with en_piso=0 in REPOSO, D=REPOSO.
REQ-017 SUBIENDO: en_piso and (pendientes[piso_actual] or piso_actual==N_PISOS-1) -> PUERTA; else SUBIENDO. BAJANDO is symmetric, with the limit at piso_actual==0.
REQ-018 ultima_dir register: set to up when Q==SUBIENDO and to down when Q==BAJANDO; otherwise held.
REQ-019 While Q==PUERTA and en_piso=1, pendientes[piso_actual] SHALL clear each cycle; the clear beats a simultaneous boton on the same bit.
REQ-020 Timer: 8-bit, held at 0 when Q!=PUERTA, increments when Q==PUERTA; D=REPOSO when timer==T_PUERTA-1, else PUERTA.
REQ-021 boton[piso_actual]=1 while Q==PUERTA SHALL reset the timer to 0 to extend the dwell.
REQ-022 No wrap: the timer saturates at T_PUERTA-1.
REQ-023 Requests at other floors are latched in any state without changing the current transition.

Reset
REQ-024 With rst_n=0 at a clk edge: pendientes=0, timer=0, ultima_dir=up.
REQ-025 While rst_n=0, D=REPOSO regardless of Q; motor outputs still follow Q.
REQ-026 Reset mid-travel or mid-dwell SHALL drop all pending requests; there is no replay.

Configuration
REQ-027 Macro ASCENSOR_PARADA_EN defined: add input parada (1 bit); parada=1 forces D=REPOSO and freezes the timer; pendientes keep latching.
REQ-028 Macro undefined: the parada port is absent and behaviour equals parada=0.

Verification
REQ-029 Reset, Q=REPOSO, en_piso=1, piso_actual=0, pulse boton=0100 -> next cycle pendientes=0100, D=SUBIENDO.
REQ-030 Q=SUBIENDO, pendientes=0100, en_piso pulses at floor 1 then floor 2 -> D=SUBIENDO at 1, D=PUERTA at 2; in PUERTA, pendientes becomes 0000.
REQ-031 Q=PUERTA from cycle 0, T_PUERTA=8 -> D=REPOSO exactly at timer=7; boton[piso_actual] at timer=5 -> timer=0, dwell extended by 6 cycles.
REQ-032 ultima_dir=up, piso_actual=1, pendientes=1001, Q=REPOSO -> D=SUBIENDO; ultima_dir=down with the same inputs -> D=BAJANDO.
REQ-033 Q=PUERTA at floor 2, boton=0100 and clear in the same cycle -> pendientes[2]=0; rst_n=0 with pendientes=1010 -> pendientes=0000, D=REPOSO.
REQ-034 ASCENSOR_PARADA_EN: Q=SUBIENDO, parada=1 -> D=REPOSO, pendientes retained; parada=0 -> normal REPOSO arbitration resumes.
